// File: rtl/exp_req_ctrl.sv
// Exception request controller in front of CP0: synchronizes raw lines, keeps sticky pending
// flags, presents one fixed-priority request at a time. Optional timer source: EXP_TIMER_EN.
module exp_req_ctrl #(
  parameter int NSRC = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_in,
  input  logic [NSRC-1:0] block_mask,
  input  logic            exp_ack,
  input  logic            eret,
`ifdef EXP_TIMER_EN
  input  logic            tmr_we,
  input  logic [31:0]     tmr_din,
  output logic [31:0]     tmr_cnt,
`endif
  output logic [NSRC-1:0] exp_src,
  output logic [1:0]      cause,
  output logic            in_service,
  output logic [NSRC-1:0] pending
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t          state, state_nxt;
  logic [NSRC-1:0] sync1, sync2, prev;
  logic [NSRC-1:0] elig, set_vec, clr_vec, tmr_set, exp_src_nxt;
  logic [1:0]      winner, win_idx;
  logic            win_vld, win_load, ack_take;

  assign elig    = pending & ~block_mask;
  assign set_vec = (sync2 & ~prev) | tmr_set;
  assign clr_vec = ack_take ? ({{(NSRC-1){1'b0}}, 1'b1} << winner) : '0;

  // Lowest eligible index wins.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_idx = 2'(i);
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = REQ;
      REQ: begin
        if (exp_ack)                 state_nxt = SERVICE;
        else if (block_mask[winner]) state_nxt = IDLE;
      end
      SERVICE: if (eret) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake: exp_src stays valid and stable in REQ until the exp_ack edge or a withdraw;
  // an ack in the same cycle as a withdraw is honoured.
  always_comb begin
    exp_src_nxt = '0;
    win_load    = 1'b0;
    ack_take    = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          exp_src_nxt = {{(NSRC-1){1'b0}}, 1'b1} << win_idx;
          win_load    = 1'b1;
        end
      end
      REQ: begin
        ack_take = exp_ack;
        if (!exp_ack && !block_mask[winner]) exp_src_nxt = exp_src;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      pending    <= '0;
      exp_src    <= '0;
      winner     <= '0;
      cause      <= '0;
      in_service <= 1'b0;
    end else begin
      sync1      <= irq_in;
      sync2      <= sync1;
      prev       <= sync2;
      pending    <= (pending & ~clr_vec) | set_vec;
      exp_src    <= exp_src_nxt;
      in_service <= (state_nxt == SERVICE);
      if (win_load) winner <= win_idx;
      if (ack_take) cause  <= winner;
    end
  end

`ifdef EXP_TIMER_EN
  logic [31:0] tmr_reload;
  logic        tmr_evt;

  // The 1->0 step fires the event and reloads in place, so a periodic count never shows 0.
  assign tmr_evt = !tmr_we && (tmr_cnt == 32'd1);
  assign tmr_set = {{(NSRC-1){1'b0}}, tmr_evt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_cnt    <= '0;
      tmr_reload <= '0;
    end else if (tmr_we) begin
      tmr_cnt    <= tmr_din;
      tmr_reload <= tmr_din;
    end else if (tmr_evt) begin
      tmr_cnt    <= tmr_reload;
    end else if (tmr_cnt != 32'd0) begin
      tmr_cnt    <= tmr_cnt - 32'd1;
    end
  end
`else
  assign tmr_set = '0;
`endif

endmodule

// File: tb/tb_exp_req_ctrl.sv
// Bench for exp_req_ctrl: cycle table of inputs/expected outputs checked through a scoreboard
// queue, plus hand-written reset and (with EXP_TIMER_EN) timer sequences.
module tb_exp_req_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] irq_in = '0;
  logic [2:0] block_mask = '0;
  logic       exp_ack = 1'b0;
  logic       eret = 1'b0;
  logic [2:0] exp_src;
  logic [1:0] cause;
  logic       in_service;
  logic [2:0] pending;
`ifdef EXP_TIMER_EN
  logic        tmr_we = 1'b0;
  logic [31:0] tmr_din = '0;
  logic [31:0] tmr_cnt;
`endif

  int test_cnt = 0;
  int fail_cnt = 0;

  logic [8:0] exp_q[$];

  typedef struct packed {
    logic [2:0] irq;
    logic [2:0] mask;
    logic       ack;
    logic       eret;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  exp_req_ctrl #(.NSRC(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .block_mask (block_mask),
    .exp_ack    (exp_ack),
    .eret       (eret),
`ifdef EXP_TIMER_EN
    .tmr_we     (tmr_we),
    .tmr_din    (tmr_din),
    .tmr_cnt    (tmr_cnt),
`endif
    .exp_src    (exp_src),
    .cause      (cause),
    .in_service (in_service),
    .pending    (pending)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] irq, input logic [2:0] mask, input logic ack,
                              input logic er, input logic [2:0] src, input logic [2:0] pend,
                              input logic [1:0] cs, input logic svc);
    vec_t v;
    v.irq  = irq;
    v.mask = mask;
    v.ack  = ack;
    v.eret = er;
    v.exp  = {src, pend, cs, svc};
    return v;
  endfunction

  // Scoreboard: pop the oldest expectation and compare it with the DUT outputs.
  task automatic sb_check(input string name);
    logic [8:0] want, got;
    got = {exp_src, pending, cause, in_service};
    if (exp_q.size() == 0) begin
      fail_cnt++;
      test_cnt++;
      $display("FAIL %s: scoreboard queue empty", name);
    end else begin
      want = exp_q.pop_front();
      test_cnt++;
      if (got !== want) begin
        fail_cnt++;
        $display("FAIL %s: got src=%b pend=%b cause=%0d svc=%b, want src=%b pend=%b cause=%0d svc=%b",
                 name, got[8:6], got[5:3], got[2:1], got[0], want[8:6], want[5:3], want[2:1], want[0]);
      end
    end
  endtask

  // Driver: apply inputs after the falling edge, sample 1 unit past the rising edge.
  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    irq_in     = v.irq;
    block_mask = v.mask;
    exp_ack    = v.ack;
    eret       = v.eret;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    sb_check(name);
  endtask

`ifdef EXP_TIMER_EN
  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] want);
    test_cnt++;
    if (got !== want) begin
      fail_cnt++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask
`endif

  initial begin
    // irq, mask, ack, eret | exp_src, pending, cause, in_service
    // single event on source 1
    vecs.push_back(mk(3'b010, 3'b000, 0, 0, 3'b000, 3'b000, 2'd0, 0));
    vecs.push_back(mk(3'b010, 3'b000, 0, 0, 3'b000, 3'b000, 2'd0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b000, 3'b010, 2'd0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b010, 3'b010, 2'd0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b010, 3'b010, 2'd0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 1, 0, 3'b000, 3'b000, 2'd1, 1));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 2'd1, 1));
    vecs.push_back(mk(3'b000, 3'b000, 0, 1, 3'b000, 3'b000, 2'd1, 0));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 2'd1, 0));
    // priority: sources 2 and 0 together, lines held high (one event each)
    vecs.push_back(mk(3'b101, 3'b000, 0, 0, 3'b000, 3'b000, 2'd1, 0));
    vecs.push_back(mk(3'b101, 3'b000, 0, 0, 3'b000, 3'b000, 2'd1, 0));
    vecs.push_back(mk(3'b101, 3'b000, 0, 0, 3'b000, 3'b101, 2'd1, 0));
    vecs.push_back(mk(3'b101, 3'b000, 0, 0, 3'b001, 3'b101, 2'd1, 0));
    vecs.push_back(mk(3'b101, 3'b000, 1, 0, 3'b000, 3'b100, 2'd0, 1));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b000, 3'b100, 2'd0, 1));
    vecs.push_back(mk(3'b000, 3'b000, 0, 1, 3'b000, 3'b100, 2'd0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b100, 3'b100, 2'd0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 1, 0, 3'b000, 3'b000, 2'd2, 1));
    vecs.push_back(mk(3'b000, 3'b000, 0, 1, 3'b000, 3'b000, 2'd2, 0));
    // ack and eret outside their states are ignored
    vecs.push_back(mk(3'b000, 3'b000, 1, 1, 3'b000, 3'b000, 2'd2, 0));
    // masking, then withdraw
    vecs.push_back(mk(3'b001, 3'b001, 0, 0, 3'b000, 3'b000, 2'd2, 0));
    vecs.push_back(mk(3'b001, 3'b001, 0, 0, 3'b000, 3'b000, 2'd2, 0));
    vecs.push_back(mk(3'b000, 3'b001, 0, 0, 3'b000, 3'b001, 2'd2, 0));
    vecs.push_back(mk(3'b000, 3'b001, 0, 0, 3'b000, 3'b001, 2'd2, 0));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b001, 3'b001, 2'd2, 0));
    vecs.push_back(mk(3'b000, 3'b001, 0, 0, 3'b000, 3'b001, 2'd2, 0));
    vecs.push_back(mk(3'b000, 3'b001, 0, 0, 3'b000, 3'b001, 2'd2, 0));
    // withdraw and ack together: ack wins
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b001, 3'b001, 2'd2, 0));
    vecs.push_back(mk(3'b000, 3'b001, 1, 0, 3'b000, 3'b000, 2'd0, 1));
    vecs.push_back(mk(3'b000, 3'b000, 0, 1, 3'b000, 3'b000, 2'd0, 0));
    // no re-arbitration while in REQ
    vecs.push_back(mk(3'b100, 3'b000, 0, 0, 3'b000, 3'b000, 2'd0, 0));
    vecs.push_back(mk(3'b100, 3'b000, 0, 0, 3'b000, 3'b000, 2'd0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b000, 3'b100, 2'd0, 0));
    vecs.push_back(mk(3'b001, 3'b000, 0, 0, 3'b100, 3'b100, 2'd0, 0));
    vecs.push_back(mk(3'b001, 3'b000, 0, 0, 3'b100, 3'b100, 2'd0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b100, 3'b101, 2'd0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b100, 3'b101, 2'd0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 1, 0, 3'b000, 3'b001, 2'd2, 1));
    vecs.push_back(mk(3'b000, 3'b000, 0, 1, 3'b000, 3'b001, 2'd2, 0));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b001, 3'b001, 2'd2, 0));
    vecs.push_back(mk(3'b000, 3'b000, 1, 0, 3'b000, 3'b000, 2'd0, 1));
    vecs.push_back(mk(3'b000, 3'b000, 0, 1, 3'b000, 3'b000, 2'd0, 0));
    // set/clear collision on source 1
    vecs.push_back(mk(3'b010, 3'b000, 0, 0, 3'b000, 3'b000, 2'd0, 0));
    vecs.push_back(mk(3'b010, 3'b000, 0, 0, 3'b000, 3'b000, 2'd0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b000, 3'b010, 2'd0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b010, 3'b010, 2'd0, 0));
    vecs.push_back(mk(3'b010, 3'b000, 0, 0, 3'b010, 3'b010, 2'd0, 0));
    vecs.push_back(mk(3'b010, 3'b000, 0, 0, 3'b010, 3'b010, 2'd0, 0));
    vecs.push_back(mk(3'b000, 3'b000, 1, 0, 3'b000, 3'b010, 2'd1, 1));
    vecs.push_back(mk(3'b000, 3'b000, 0, 1, 3'b000, 3'b010, 2'd1, 0));
    vecs.push_back(mk(3'b000, 3'b000, 0, 0, 3'b010, 3'b010, 2'd1, 0));
    vecs.push_back(mk(3'b000, 3'b000, 1, 0, 3'b000, 3'b000, 2'd1, 1));
    vecs.push_back(mk(3'b000, 3'b000, 0, 1, 3'b000, 3'b000, 2'd1, 0));

    // Reset
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(9'd0);
    sb_check("reset_state");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-REQ: outputs drop asynchronously, no ack needed
    step(mk(3'b010, 3'b000, 0, 0, 3'b000, 3'b000, 2'd1, 0), "rq_sync0");
    step(mk(3'b010, 3'b000, 0, 0, 3'b000, 3'b000, 2'd1, 0), "rq_sync1");
    step(mk(3'b000, 3'b000, 0, 0, 3'b000, 3'b010, 2'd1, 0), "rq_pend");
    step(mk(3'b000, 3'b000, 0, 0, 3'b010, 3'b010, 2'd1, 0), "rq_req");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back(9'd0);
    sb_check("async_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      step(mk(3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 2'd0, 0), $sformatf("post_rst%0d", i));
    // Latency of a fresh event after reset
    step(mk(3'b001, 3'b000, 0, 0, 3'b000, 3'b000, 2'd0, 0), "lat_k");
    step(mk(3'b001, 3'b000, 0, 0, 3'b000, 3'b000, 2'd0, 0), "lat_k1");
    step(mk(3'b000, 3'b000, 0, 0, 3'b000, 3'b001, 2'd0, 0), "lat_k2");
    step(mk(3'b000, 3'b000, 0, 0, 3'b001, 3'b001, 2'd0, 0), "lat_k3");
    step(mk(3'b000, 3'b000, 1, 0, 3'b000, 3'b000, 2'd0, 1), "lat_ack");
    step(mk(3'b000, 3'b000, 0, 1, 3'b000, 3'b000, 2'd0, 0), "lat_eret");

`ifdef EXP_TIMER_EN
    begin
      logic [31:0] cnt_seq[10];
      cnt_seq = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd5};
      chk32("tmr_reset", tmr_cnt, 32'd0);
      @(negedge clk);
      block_mask = 3'b001;
      tmr_we = 1'b1;
      tmr_din = 32'd5;
      @(negedge clk);
      tmr_we = 1'b0;
      chk32("tmr_load", tmr_cnt, 32'd5);
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        chk32($sformatf("tmr_cnt%0d", i), tmr_cnt, cnt_seq[i]);
        if (i == 3) chk32("tmr_pend_before", {29'd0, pending}, 32'd0);
        if (i == 4) chk32("tmr_pend_set", {29'd0, pending}, 32'd1);
      end
      @(negedge clk);
      tmr_we = 1'b1;
      tmr_din = 32'd0;
      @(negedge clk);
      tmr_we = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk32("tmr_stopped", tmr_cnt, 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
